// File: rtl/vga_output_stage.sv
// vga_output_stage: final pixel path of the VGA display.
// Composites LAYERS sprite layers over a background tile with fixed priority
// (layer 0 highest), delays the result PIPE_STAGES cycles together with the
// display enable, and blanks the colour outputs outside active video.
// Optional fade engine (brightness FSM and per-channel multiply) is compiled
// in only when the macro VGA_FADE_EN is defined; otherwise brightness is
// fixed at full scale and the fade inputs are ignored.
// frame_count counts frame_start pulses in every build.

module vga_output_stage #(
    parameter int COLOR_BITS       = 4,
    parameter int LAYERS           = 3,
    parameter int PIPE_STAGES      = 2,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic                             vga_clock,
    input  logic                             reset,
    input  logic [LAYERS*3*COLOR_BITS-1:0]   layer_rgb,
    input  logic [LAYERS-1:0]                layer_opaque,
    input  logic [3*COLOR_BITS-1:0]          bg_rgb,
    input  logic                             display_enable,
    input  logic                             frame_start,
    input  logic                             fade_req,
    input  logic                             fade_dir,
    output logic [COLOR_BITS-1:0]            vga_red,
    output logic [COLOR_BITS-1:0]            vga_green,
    output logic [COLOR_BITS-1:0]            vga_blue,
    output logic                             pixel_valid,
    output logic                             fade_busy,
    output logic [15:0]                      frame_count
);

    localparam int PIX_W = 3 * COLOR_BITS;
    // Registers ahead of the output stage: stage 1 plus the pure delay stages.
    localparam int DLY   = PIPE_STAGES - 1;

    logic [PIX_W-1:0] comp_s;
    logic [PIX_W-1:0] pix_r [0:DLY-1];
    logic [DLY-1:0]   en_r;
    logic [PIX_W-1:0] last_pix_s;
    logic             last_en_s;

    // Fixed-priority composite: walk from the lowest-priority layer upward so
    // the lowest-indexed opaque layer is the last one to overwrite the colour.
    always_comb begin
        comp_s = bg_rgb;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            comp_s = layer_opaque[i] ? layer_rgb[i*PIX_W +: PIX_W] : comp_s;
        end
    end

    // Stage 1 capture of the composited colour and enable, followed by the delay chain.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DLY; i++) begin
                pix_r[i] <= {PIX_W{1'b0}};
                en_r[i]  <= 1'b0;
            end
        end else begin
            pix_r[0] <= comp_s;
            en_r[0]  <= display_enable;
            for (int i = 1; i < DLY; i++) begin
                pix_r[i] <= pix_r[i-1];
                en_r[i]  <= en_r[i-1];
            end
        end
    end

    assign last_pix_s = pix_r[DLY-1];
    assign last_en_s  = en_r[DLY-1];

`ifdef VGA_FADE_EN

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_FADE_OUT = 2'd2
    } fade_state_t;

    localparam int                STEP_W    = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(32'd1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    fade_state_t       state_r;
    logic [4:0]        bright_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic              fade_busy_r;

    // out = (c * B) >> 4 with B in 0..16; B = 16 is an exact pass-through.
    function automatic logic [COLOR_BITS-1:0] scale_ch(input logic [COLOR_BITS-1:0] c,
                                                        input logic [4:0]            b);
        return COLOR_BITS'(({5'd0, c} * {{COLOR_BITS{1'b0}}, b}) >> 3'd4);
    endfunction

    // Fade FSM: a request always wins over a coincident frame_start and restarts
    // the step counter; brightness only moves on frame_start so it never changes mid-frame.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            bright_r    <= 5'd16;
            step_cnt_r  <= STEP_ZERO;
            fade_busy_r <= 1'b0;
        end else if (fade_req) begin
            step_cnt_r <= STEP_ZERO;
            if (fade_dir) begin
                if (bright_r < 5'd16) begin
                    state_r     <= ST_FADE_IN;
                    fade_busy_r <= 1'b1;
                end else begin
                    state_r     <= ST_IDLE;
                    fade_busy_r <= 1'b0;
                end
            end else begin
                if (bright_r > 5'd0) begin
                    state_r     <= ST_FADE_OUT;
                    fade_busy_r <= 1'b1;
                end else begin
                    state_r     <= ST_IDLE;
                    fade_busy_r <= 1'b0;
                end
            end
        end else if (frame_start) begin
            case (state_r)
                ST_IDLE: begin
                    step_cnt_r <= STEP_ZERO;
                end
                ST_FADE_IN: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_r <= STEP_ZERO;
                        bright_r   <= bright_r + 5'd1;
                        if (bright_r == 5'd15) begin
                            state_r     <= ST_IDLE;
                            fade_busy_r <= 1'b0;
                        end else begin
                            state_r     <= ST_FADE_IN;
                            fade_busy_r <= 1'b1;
                        end
                    end else begin
                        step_cnt_r <= step_cnt_r + STEP_ONE;
                    end
                end
                ST_FADE_OUT: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_r <= STEP_ZERO;
                        bright_r   <= bright_r - 5'd1;
                        if (bright_r == 5'd1) begin
                            state_r     <= ST_IDLE;
                            fade_busy_r <= 1'b0;
                        end else begin
                            state_r     <= ST_FADE_OUT;
                            fade_busy_r <= 1'b1;
                        end
                    end else begin
                        step_cnt_r <= step_cnt_r + STEP_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    step_cnt_r  <= STEP_ZERO;
                    fade_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign fade_busy = fade_busy_r;

    // Output stage: brightness scaling and blanking on the delayed enable.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            vga_red     <= {COLOR_BITS{1'b0}};
            vga_green   <= {COLOR_BITS{1'b0}};
            vga_blue    <= {COLOR_BITS{1'b0}};
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= last_en_s;
            if (last_en_s) begin
                vga_red   <= scale_ch(last_pix_s[PIX_W-1 -: COLOR_BITS], bright_r);
                vga_green <= scale_ch(last_pix_s[2*COLOR_BITS-1 -: COLOR_BITS], bright_r);
                vga_blue  <= scale_ch(last_pix_s[COLOR_BITS-1:0], bright_r);
            end else begin
                vga_red   <= {COLOR_BITS{1'b0}};
                vga_green <= {COLOR_BITS{1'b0}};
                vga_blue  <= {COLOR_BITS{1'b0}};
            end
        end
    end

`else

    // Fade engine absent: brightness is permanently full scale.
    logic unused_fade_s;
    assign unused_fade_s = fade_req ^ fade_dir;
    assign fade_busy     = 1'b0;

    // Output stage: blanking on the delayed enable, colour passed unchanged.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            vga_red     <= {COLOR_BITS{1'b0}};
            vga_green   <= {COLOR_BITS{1'b0}};
            vga_blue    <= {COLOR_BITS{1'b0}};
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= last_en_s;
            if (last_en_s) begin
                vga_red   <= last_pix_s[PIX_W-1 -: COLOR_BITS];
                vga_green <= last_pix_s[2*COLOR_BITS-1 -: COLOR_BITS];
                vga_blue  <= last_pix_s[COLOR_BITS-1:0];
            end else begin
                vga_red   <= {COLOR_BITS{1'b0}};
                vga_green <= {COLOR_BITS{1'b0}};
                vga_blue  <= {COLOR_BITS{1'b0}};
            end
        end
    end

`endif

    // Free-running frame counter, wraps 0xFFFF -> 0.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            frame_count <= 16'd0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_output_stage.sv
// Testbench for vga_output_stage (default parameters).
// Pixel path is checked through a due-cycle scoreboard; the fade sequence is
// checked against a small brightness model. Fade-specific expectations adapt
// to whether VGA_FADE_EN is defined.

module tb_vga_output_stage;

    localparam int PIPE = 2;
    localparam int FSF  = 4;
`ifdef VGA_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic        vga_clock = 1'b0;
    logic        reset     = 1'b1;
    logic [35:0] layer_rgb = 36'd0;
    logic [2:0]  layer_opaque = 3'd0;
    logic [11:0] bg_rgb = 12'd0;
    logic        display_enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        fade_req = 1'b0;
    logic        fade_dir = 1'b0;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic        pixel_valid, fade_busy;
    logic [15:0] frame_count;

    vga_output_stage dut (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .layer_rgb      (layer_rgb),
        .layer_opaque   (layer_opaque),
        .bg_rgb         (bg_rgb),
        .display_enable (display_enable),
        .frame_start    (frame_start),
        .fade_req       (fade_req),
        .fade_dir       (fade_dir),
        .vga_red        (vga_red),
        .vga_green      (vga_green),
        .vga_blue       (vga_blue),
        .pixel_valid    (pixel_valid),
        .fade_busy      (fade_busy),
        .frame_count    (frame_count)
    );

    always #5 vga_clock = ~vga_clock;

    typedef struct {
        int         due;
        logic       valid;
        logic [11:0] rgb;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          b_m      = 16;
    int          cnt_m    = 0;
    bit          busy_m   = 1'b0;
    bit          dir_m    = 1'b0;
    logic [15:0] fc_m     = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] faded_white(input int b);
        logic [3:0] s;
        s = 4'((15 * b) / 16);
        return {s, s, s};
    endfunction

    // One clock; afterwards retire every scoreboard entry that is due.
    task automatic tick();
        exp_t e;
        @(posedge vga_clock);
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check("pix_rgb", 32'({vga_red, vga_green, vga_blue}), 32'(e.rgb));
            check("pix_valid", 32'(pixel_valid), 32'(e.valid));
        end
    endtask

    task automatic drive_pix(input logic [2:0] op, input logic [11:0] l2, input logic [11:0] l1,
                             input logic [11:0] l0, input logic [11:0] bg, input logic de,
                             input logic [11:0] exp_rgb);
        exp_t e;
        layer_opaque   = op;
        layer_rgb      = {l2, l1, l0};
        bg_rgb         = bg;
        display_enable = de;
        e.due   = cyc + PIPE;
        e.valid = de;
        e.rgb   = de ? exp_rgb : 12'h000;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic fade_checks(input string tag);
        check({tag, "_rgb"}, 32'({vga_red, vga_green, vga_blue}), 32'(faded_white(b_m)));
        check({tag, "_busy"}, 32'(fade_busy), 32'(busy_m));
        check({tag, "_fc"}, 32'(frame_count), 32'(fc_m));
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fc_m++;
        if (busy_m) begin
            cnt_m++;
            if (cnt_m == FSF) begin
                cnt_m = 0;
                b_m   = dir_m ? b_m + 1 : b_m - 1;
                if (b_m == 16 || b_m == 0) busy_m = 1'b0;
            end
        end
        tick();
        fade_checks("pulse");
    endtask

    task automatic req(input logic dir, input logic with_frame);
        fade_req    = 1'b1;
        fade_dir    = dir;
        frame_start = with_frame;
        tick();
        fade_req    = 1'b0;
        frame_start = 1'b0;
        if (with_frame) fc_m++;
        if (FADE) begin
            cnt_m = 0;
            if (dir) begin
                busy_m = (b_m < 16);
            end else begin
                busy_m = (b_m > 0);
            end
            dir_m = dir;
        end
        tick();
        fade_checks("req");
    endtask

    initial begin
        // Asynchronous reset with no clock edge needed
        #3 reset = 1'b0;
        #2;
        check("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h0);
        check("rst_valid", 32'(pixel_valid), 32'h0);
        check("rst_busy", 32'(fade_busy), 32'h0);
        check("rst_fc", 32'(frame_count), 32'h0);
        @(negedge vga_clock);
        reset = 1'b1;

        // Pixel path: priority, blanking and background
        drive_pix(3'b101, 12'h0F0, 12'h00F, 12'hF00, 12'h111, 1'b1, 12'hF00);
        drive_pix(3'b000, 12'h0F0, 12'h00F, 12'hF00, 12'h48C, 1'b0, 12'h000);
        drive_pix(3'b000, 12'h0F0, 12'h00F, 12'hF00, 12'h48C, 1'b1, 12'h48C);
        drive_pix(3'b110, 12'h0F0, 12'h00F, 12'hF00, 12'h48C, 1'b1, 12'h00F);
        drive_pix(3'b100, 12'h0F0, 12'h00F, 12'hF00, 12'h48C, 1'b1, 12'h0F0);
        drive_pix(3'b111, 12'h0F0, 12'h00F, 12'hF00, 12'h48C, 1'b0, 12'h000);
        drive_pix(3'b111, 12'h0F0, 12'h00F, 12'hF00, 12'h48C, 1'b1, 12'hF00);
        drive_pix(3'b010, 12'hABC, 12'h123, 12'h456, 12'h789, 1'b1, 12'h123);
        drive_pix(3'b000, 12'hABC, 12'h123, 12'h456, 12'h789, 1'b1, 12'h789);
        display_enable = 1'b0;
        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        // Fade sequence on a white pixel
        layer_opaque   = 3'b001;
        layer_rgb      = {12'h000, 12'h000, 12'hFFF};
        display_enable = 1'b1;
        repeat (3) tick();
        fade_checks("full");

        req(1'b0, 1'b0);
        repeat (32) pulse();
`ifdef VGA_FADE_EN
        check("b8_red", 32'(vga_red), 32'h7);
`endif
        req(1'b1, 1'b0);
        repeat (32) begin
            pulse();
            check("rev_min", 32'(vga_red >= 4'd7), 32'h1);
        end
        req(1'b0, 1'b0);
        repeat (64) pulse();
`ifdef VGA_FADE_EN
        check("out0_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h0);
        check("out0_busy", 32'(fade_busy), 32'h0);
`endif
        req(1'b0, 1'b0);
        req(1'b1, 1'b0);
        repeat (15) pulse();
        req(1'b1, 1'b1);
        repeat (20) pulse();
`ifdef VGA_FADE_EN
        check("coinc_red", 32'(vga_red), 32'h7);
`endif
        req(1'b0, 1'b0);
        repeat (12) pulse();
`ifdef VGA_FADE_EN
        check("b5_bright", 32'(dut.bright_r), 32'd5);
`endif

        // Async reset mid-fade, between clock edges
        #2 reset = 1'b0;
        #1;
        check("mrst_busy", 32'(fade_busy), 32'h0);
        check("mrst_fc", 32'(frame_count), 32'h0);
        check("mrst_valid", 32'(pixel_valid), 32'h0);
        check("mrst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h0);
`ifdef VGA_FADE_EN
        check("mrst_bright", 32'(dut.bright_r), 32'd16);
`endif
        b_m = 16; cnt_m = 0; busy_m = 1'b0; fc_m = 16'd0;
        @(negedge vga_clock);
        reset = 1'b1;
        tick();
        tick();
        check("refill_rgb", 32'({vga_red, vga_green, vga_blue}), 32'hFFF);
        check("refill_valid", 32'(pixel_valid), 32'h1);
        check("refill_busy", 32'(fade_busy), 32'h0);

        // Frame counter wrap
        frame_start = 1'b1;
        repeat (65535) tick();
        frame_start = 1'b0;
        check("fc_max", 32'(frame_count), 32'hFFFF);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fc_wrap", 32'(frame_count), 32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
